// File: rtl/bitclk_lock_ctrl.sv
// Lock-state controller for bit-clock recovery: sequences the period estimator and qualifies data edges.
// Define BITCLK_LOCK_HOLDOVER_EN to include the HOLDOVER state and its hold timer.
module bitclk_lock_ctrl #(
  parameter int CLK_LEN     = 16,
  parameter int ACQ_EDGES   = 32,
  parameter int LOCK_EDGES  = 16,
  parameter int BAD_LIMIT   = 4,
  parameter int TOL_SHIFT   = 3,
  parameter int LOSS_CYCLES = 4096,
  parameter int HOLD_CYCLES = 65536
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               restart,
  input  logic               edge_pulse,
  input  logic [CLK_LEN-1:0] est_period,
  output logic               est_clear,
  output logic               est_freeze,
  output logic               locked,
  output logic               holdover,
  output logic [2:0]         state,
  output logic [7:0]         err_count
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ACQ    = 3'd1,
    S_VERIFY = 3'd2,
    S_LOCKED = 3'd3,
    S_HOLD   = 3'd4
  } state_t;

  localparam int ACQ_W  = $clog2(ACQ_EDGES + 1);
  localparam int GOOD_W = $clog2(LOCK_EDGES + 1);
  localparam int BAD_W  = $clog2(BAD_LIMIT + 1);
  localparam int SIL_W  = $clog2(LOSS_CYCLES + 1);

  state_t             state_q, state_nxt;
  logic [ACQ_W-1:0]   acq_q, acq_nxt;
  logic [GOOD_W-1:0]  good_q, good_nxt;
  logic [BAD_W-1:0]   bad_q, bad_nxt;
  logic [SIL_W-1:0]   sil_q, sil_nxt;
  logic [CLK_LEN-1:0] phase_q, phase_nxt;
  logic [CLK_LEN-1:0] tol;
  logic [7:0]         err_q, err_nxt;
  logic               edge_good;
  logic               loss;
  logic               acq_entry;
`ifdef BITCLK_LOCK_HOLDOVER_EN
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  logic [HOLD_W-1:0]  hold_q, hold_nxt;
`endif

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Phase is the cycle count since the last edge, so an on-time edge sees est_period-1.
  assign tol       = est_period >> TOL_SHIFT;
  assign edge_good = (est_period >= CLK_LEN'(4)) &&
                     ((phase_q <= tol) || (phase_q >= est_period - tol));
  assign loss      = (sil_q == SIL_W'(LOSS_CYCLES));

  always_comb begin
    state_nxt = state_q;
    acq_nxt   = acq_q;
    good_nxt  = good_q;
    bad_nxt   = bad_q;
    err_nxt   = err_q;
    acq_entry = 1'b0;
    phase_nxt = (edge_pulse || (phase_q == est_period - CLK_LEN'(1))) ? '0 : phase_q + CLK_LEN'(1);
    sil_nxt   = edge_pulse ? '0 : (loss ? sil_q : sil_q + SIL_W'(1));
`ifdef BITCLK_LOCK_HOLDOVER_EN
    hold_nxt  = hold_q;
`endif

    case (state_q)
      S_IDLE: begin
        acq_entry = enable;
      end
      S_ACQ: begin
        if (restart) begin
          acq_entry = 1'b1;
        end else if (edge_pulse) begin
          acq_nxt = acq_q + ACQ_W'(1);
          if (acq_q + ACQ_W'(1) == ACQ_W'(ACQ_EDGES)) state_nxt = S_VERIFY;
        end
      end
      S_VERIFY: begin
        if (restart) begin
          acq_entry = 1'b1;
        end else if (edge_pulse) begin
          if (edge_good) begin
            good_nxt = good_q + GOOD_W'(1);
            if (good_q + GOOD_W'(1) == GOOD_W'(LOCK_EDGES)) begin
              state_nxt = S_LOCKED;
              bad_nxt   = '0;
            end
          end else begin
            good_nxt = '0;
            err_nxt  = sat_inc8(err_q);
          end
        end else if (loss) begin
          acq_entry = 1'b1;
        end
      end
      S_LOCKED: begin
        if (restart) begin
          acq_entry = 1'b1;
        end else if (edge_pulse) begin
          if (edge_good) begin
            bad_nxt = '0;
          end else begin
            bad_nxt = bad_q + BAD_W'(1);
            err_nxt = sat_inc8(err_q);
            if (bad_q + BAD_W'(1) == BAD_W'(BAD_LIMIT)) acq_entry = 1'b1;
          end
        end else if (loss) begin
`ifdef BITCLK_LOCK_HOLDOVER_EN
          state_nxt = S_HOLD;
          hold_nxt  = '0;
`else
          acq_entry = 1'b1;
`endif
        end
      end
`ifdef BITCLK_LOCK_HOLDOVER_EN
      S_HOLD: begin
        if (restart) begin
          acq_entry = 1'b1;
        end else if (edge_pulse) begin
          if (edge_good) begin
            state_nxt = S_LOCKED;
            bad_nxt   = '0;
          end else begin
            acq_entry = 1'b1;
          end
        end else if (hold_q == HOLD_W'(HOLD_CYCLES)) begin
          acq_entry = 1'b1;
        end else begin
          hold_nxt = hold_q + HOLD_W'(1);
        end
      end
`endif
      default: state_nxt = S_IDLE;
    endcase

    // Re-acquisition starts from a clean slate; disable overrides everything.
    if (acq_entry || !enable) begin
      state_nxt = enable ? S_ACQ : S_IDLE;
      acq_entry = enable;
      acq_nxt   = '0;
      good_nxt  = '0;
      bad_nxt   = '0;
      err_nxt   = '0;
      phase_nxt = '0;
      sil_nxt   = '0;
`ifdef BITCLK_LOCK_HOLDOVER_EN
      hold_nxt  = '0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      acq_q      <= '0;
      good_q     <= '0;
      bad_q      <= '0;
      sil_q      <= '0;
      phase_q    <= '0;
      err_q      <= '0;
      est_clear  <= 1'b0;
      est_freeze <= 1'b1;
      locked     <= 1'b0;
    end else begin
      state_q    <= state_nxt;
      acq_q      <= acq_nxt;
      good_q     <= good_nxt;
      bad_q      <= bad_nxt;
      sil_q      <= sil_nxt;
      phase_q    <= phase_nxt;
      err_q      <= err_nxt;
      est_clear  <= acq_entry;
      est_freeze <= (state_nxt != S_ACQ) && (state_nxt != S_VERIFY);
      locked     <= (state_nxt == S_LOCKED);
    end
  end

`ifdef BITCLK_LOCK_HOLDOVER_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_q   <= '0;
      holdover <= 1'b0;
    end else begin
      hold_q   <= hold_nxt;
      holdover <= (state_nxt == S_HOLD);
    end
  end
`else
  assign holdover = 1'b0;
`endif

  assign state     = state_q;
  assign err_count = err_q;

endmodule

// File: tb/tb_bitclk_lock_ctrl.sv
// Directed bench for bitclk_lock_ctrl: vector table for control sequencing plus hand-written
// multi-cycle sequences for acquisition, lock, fault, loss and error saturation.
`timescale 1ns/1ps
module tb_bitclk_lock_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        restart = 1'b0;
  logic        edge_pulse = 1'b0;
  logic [15:0] est_period = 16'd20;
  logic        est_clear;
  logic        est_freeze;
  logic        locked;
  logic        holdover;
  logic [2:0]  state;
  logic [7:0]  err_count;

  int nvec  = 0;
  int nfail = 0;

  bitclk_lock_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .restart    (restart),
    .edge_pulse (edge_pulse),
    .est_period (est_period),
    .est_clear  (est_clear),
    .est_freeze (est_freeze),
    .locked     (locked),
    .holdover   (holdover),
    .state      (state),
    .err_count  (err_count)
  );

  always #2 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, nvec=%0d", nvec);
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic       en;
    logic       rs;
    logic       ed;
    logic [2:0] st;
    logic       clr;
    logic       frz;
    logic       lk;
    logic [7:0] err;
  } vec_t;

  vec_t vecs [9];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    nvec++;
    if (act < lo || act > hi) begin
      nfail++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic chk_out(input string name, input logic [2:0] st, input logic clr, input logic frz,
                         input logic lk, input logic hd, input logic [7:0] err);
    chk({name, ".state"}, state, st);
    chk({name, ".est_clear"}, est_clear, clr);
    chk({name, ".est_freeze"}, est_freeze, frz);
    chk({name, ".locked"}, locked, lk);
    chk({name, ".holdover"}, holdover, hd);
    chk({name, ".err_count"}, err_count, err);
  endtask

  // gap-1 quiet cycles followed by one edge cycle; the edge sees phase gap-1.
  task automatic send_edge(input int gap);
    edge_pulse = 1'b0;
    repeat (gap - 1) tick();
    edge_pulse = 1'b1;
    tick();
    edge_pulse = 1'b0;
  endtask

  task automatic wait_leave(input logic [2:0] from, input int max, output int n);
    n = 0;
    while (state === from && n < max) begin
      tick();
      n++;
    end
  endtask

  // From a freshly entered ACQUIRE at period 20: 32 acquisition edges then 16 good edges.
  task automatic acquire_lock(input string name);
    repeat (48) send_edge(20);
    chk({name, ".locked_state"}, state, 3'd3);
  endtask

  initial begin
    int n;
    int g;
    logic seen_lock;

    vecs[0] = '{en:1'b0, rs:1'b0, ed:1'b0, st:3'd0, clr:1'b0, frz:1'b1, lk:1'b0, err:8'd0};
    vecs[1] = '{en:1'b1, rs:1'b0, ed:1'b0, st:3'd1, clr:1'b1, frz:1'b0, lk:1'b0, err:8'd0};
    vecs[2] = '{en:1'b1, rs:1'b0, ed:1'b0, st:3'd1, clr:1'b0, frz:1'b0, lk:1'b0, err:8'd0};
    vecs[3] = '{en:1'b1, rs:1'b0, ed:1'b1, st:3'd1, clr:1'b0, frz:1'b0, lk:1'b0, err:8'd0};
    vecs[4] = '{en:1'b0, rs:1'b0, ed:1'b0, st:3'd0, clr:1'b0, frz:1'b1, lk:1'b0, err:8'd0};
    vecs[5] = '{en:1'b0, rs:1'b1, ed:1'b0, st:3'd0, clr:1'b0, frz:1'b1, lk:1'b0, err:8'd0};
    vecs[6] = '{en:1'b0, rs:1'b0, ed:1'b1, st:3'd0, clr:1'b0, frz:1'b1, lk:1'b0, err:8'd0};
    vecs[7] = '{en:1'b1, rs:1'b1, ed:1'b0, st:3'd1, clr:1'b1, frz:1'b0, lk:1'b0, err:8'd0};
    vecs[8] = '{en:1'b0, rs:1'b0, ed:1'b1, st:3'd0, clr:1'b0, frz:1'b1, lk:1'b0, err:8'd0};

    // Reset dominates enable.
    rst_n  = 1'b0;
    enable = 1'b1;
    repeat (3) tick();
    chk_out("reset", 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    enable = 1'b0;
    rst_n  = 1'b1;

    for (int i = 0; i < 9; i++) begin
      enable     = vecs[i].en;
      restart    = vecs[i].rs;
      edge_pulse = vecs[i].ed;
      tick();
      chk_out($sformatf("vec%0d", i), vecs[i].st, vecs[i].clr, vecs[i].frz, vecs[i].lk, 1'b0,
              vecs[i].err);
    end
    enable = 1'b0; restart = 1'b0; edge_pulse = 1'b0;

    // Enable, acquire, verify and lock at period 20.
    est_period = 16'd20;
    enable = 1'b1;
    tick();
    chk_out("en_acq", 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    tick();
    chk("en_acq2.est_clear", est_clear, 1'b0);
    repeat (31) send_edge(20);
    chk("acq31.state", state, 3'd1);
    send_edge(20);
    chk_out("acq32", 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    repeat (15) send_edge(20);
    chk_out("ver15", 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    send_edge(20);
    chk_out("ver16", 3'd3, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0);

    // Four consecutive edges at phase 10 break lock.
    for (int i = 1; i <= 3; i++) begin
      send_edge(11);
      chk_out($sformatf("bad%0d", i), 3'd3, 1'b0, 1'b1, 1'b1, 1'b0, 8'(i));
    end
    send_edge(11);
    chk_out("bad4", 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);

    // Relock, then silence.
    acquire_lock("relock1");
    wait_leave(3'd3, 5000, n);
    chk_range("loss_cycles", n, 4096, 4098);
`ifdef BITCLK_LOCK_HOLDOVER_EN
    chk_out("loss_hold", 3'd4, 1'b0, 1'b1, 1'b0, 1'b1, 8'd0);
    g = 20 - (n % 20);
    send_edge(g);
    chk_out("hold_relock", 3'd3, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0);
    wait_leave(3'd3, 5000, n);
    chk("loss2.state", state, 3'd4);
    wait_leave(3'd4, 70000, n);
    chk_range("hold_cycles", n, 65536, 65538);
    chk_out("hold_timeout", 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
`else
    g = 0;
    chk_out("loss_acq", 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
`endif

    // Period below 4: every VERIFY edge is bad; err_count saturates.
    est_period = 16'd2;
    restart = 1'b1;
    tick();
    restart = 1'b0;
    chk("p2_restart.est_clear", est_clear, 1'b1);
    repeat (32) send_edge(1);
    chk("p2_verify.state", state, 3'd2);
    seen_lock = 1'b0;
    send_edge(1);
    chk("p2_err1", err_count, 8'd1);
    for (int i = 0; i < 259; i++) begin
      send_edge(1);
      if (locked === 1'b1 || state === 3'd3) seen_lock = 1'b1;
      if (i == 253) chk("p2_err255", err_count, 8'd255);
    end
    chk_out("p2_sat", 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 8'd255);
    chk("p2_never_locked", seen_lock, 1'b0);

    // Restart and edge in the same cycle while locked.
    est_period = 16'd20;
    restart = 1'b1;
    tick();
    restart = 1'b0;
    acquire_lock("relock2");
    restart = 1'b1;
    edge_pulse = 1'b1;
    tick();
    restart = 1'b0;
    edge_pulse = 1'b0;
    chk_out("rs_edge", 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);

    // Disable mid-VERIFY clears counters.
    repeat (32) send_edge(20);
    send_edge(11);
    chk_out("ver_bad", 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1);
    enable = 1'b0;
    tick();
    chk_out("disable", 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    enable = 1'b1;
    tick();
    chk_out("reenable", 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    repeat (31) send_edge(20);
    chk("reacq31.state", state, 3'd1);
    send_edge(20);
    chk_out("reacq32", 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/bitclk_lock_ctrl.md
# bitclk_lock_ctrl

Lock-state controller for the bit-clock recovery datapath. It sequences the period estimator (clear, free-run, freeze), qualifies incoming data edges against the current period estimate, and reports lock, holdover and error status. It sits between the edge detector and the period estimator / recovered-clock generator, in the 300 MHz domain.

## Interface

Parameters:
- CLK_LEN, 16: width of period estimate and phase counter.
- ACQ_EDGES, 32: falling edges seen in ACQUIRE before entering VERIFY.
- LOCK_EDGES, 16: consecutive good edges required to declare lock.
- BAD_LIMIT, 4: consecutive bad edges in LOCKED that force re-acquisition.
- TOL_SHIFT, 3: edge tolerance = est_period >> TOL_SHIFT.
- LOSS_CYCLES, 4096: edge-free cycles that count as signal loss.
- HOLD_CYCLES, 65536: maximum holdover duration in cycles.

Ports:
- clk  in  1  system clock (300 MHz global).
- rst_n  in  1  synchronous, active-low reset.
- enable  in  1  level; low forces IDLE.
- restart  in  1  one-cycle pulse; forces re-acquisition.
- edge_pulse  in  1  one-cycle pulse per qualifying data edge.
- est_period  in  CLK_LEN  current period estimate from the estimator.
- est_clear  out  1  one-cycle pulse; estimator resets its period to all-ones.
- est_freeze  out  1  level; estimator must not update while high.
- locked  out  1  lock indicator.
- holdover  out  1  holdover indicator.
- state  out  3  encoded state: IDLE=0, ACQUIRE=1, VERIFY=2, LOCKED=3, HOLDOVER=4.
- err_count  out  8  saturating count of bad edges since the last est_clear.

## Operation

- Phase counter (CLK_LEN bits): zeroed on every edge_pulse, otherwise increments and wraps to 0 when it reaches est_period−1.
- Good edge: phase ≤ tol or phase ≥ est_period − tol, with est_period ≥ 4. Any edge with est_period < 4 is bad.
- Silence counter: zeroed on edge_pulse, saturates at LOSS_CYCLES; "loss" = silence counter == LOSS_CYCLES.
- IDLE: est_freeze=1; all counters held at 0. enable=1 → ACQUIRE.
- ACQUIRE: est_freeze=0; counts edges (edge class ignored). After ACQ_EDGES edges → VERIFY. Loss: stay.
- VERIFY: est_freeze=0. Good edge increments the good count; bad edge zeroes it and increments err_count. Good count == LOCK_EDGES → LOCKED. Loss → ACQUIRE.
- LOCKED: est_freeze=1, locked=1. Bad edge increments the bad count and err_count; good edge zeroes the bad count. Bad count == BAD_LIMIT → ACQUIRE. Loss → HOLDOVER.
- HOLDOVER: est_freeze=1, holdover=1; hold timer runs. Good edge → LOCKED; bad edge → ACQUIRE; timer == HOLD_CYCLES → ACQUIRE.
- Every entry into ACQUIRE (from IDLE, restart, or a fault) pulses est_clear, zeroes err_count and zeroes all state counters.
- Priority: rst_n > enable low > restart > edge event > loss/timer.
- restart while enable=0 is ignored.
- edge_pulse and loss in the same cycle: the edge wins and the silence counter clears.
- err_count saturates at 255.

## Timing

- Reset: state=IDLE, est_clear=0, est_freeze=1, locked=0, holdover=0, err_count=0.
- All outputs are registered. A state transition is visible one cycle after the triggering input.
- est_clear is high exactly during the first cycle in which state==ACQUIRE.
- locked rises in the cycle after the LOCK_EDGES-th good edge_pulse.
- est_period is sampled on the same edge as edge_pulse; the estimator must present its pre-update value.

## Configuration

- BITCLK_LOCK_HOLDOVER_EN defined: HOLDOVER state and hold timer are present as described above.
- Not defined: loss in LOCKED goes directly to ACQUIRE (with est_clear); holdover is tied 0; state value 4 never occurs.

## Test plan

- Reset, then enable=1: state 0→1 next cycle, est_clear high exactly 1 cycle, est_freeze=0.
- est_period=20, edges every 20 cycles: VERIFY after 32 edges, locked=1 one cycle after the 16th subsequent edge, err_count=0.
- Locked at period 20; inject 4 edges at phase 10: state→ACQUIRE, est_clear pulse, locked=0, err_count=0 after the clear.
- Locked; stop edges for 4096 cycles: holdover=1; an edge at a multiple of 20 → LOCKED; with no edge for 65536 cycles → ACQUIRE. Without the macro, loss → ACQUIRE.
- est_period=2 in VERIFY: every edge is bad, err_count increments and saturates at 255, and lock is never asserted.
- restart and edge_pulse in the same cycle while LOCKED → ACQUIRE. Deassert enable mid-VERIFY → IDLE next cycle with counters cleared.
